// File: rtl/reaction_timer_ctrl_if.sv
// rtl/reaction_timer_ctrl_if.sv - button/LFSR inputs and display-side outputs of the reaction timer
interface reaction_timer_ctrl_if;
    logic        clear;
    logic        start;
    logic        stop;
    logic        rand_done;
    logic [13:0] rand_num;
    logic        rand_start;
    logic        led;
    logic [13:0] rt_ms;
    logic        result_valid;
    logic        too_early;
    logic        timeout;

    modport master (
        output clear, start, stop, rand_done, rand_num,
        input  rand_start, led, rt_ms, result_valid, too_early, timeout
    );

    modport slave (
        input  clear, start, stop, rand_done, rand_num,
        output rand_start, led, rt_ms, result_valid, too_early, timeout
    );
endinterface

// File: rtl/reaction_timer_ctrl.sv
// rtl/reaction_timer_ctrl.sv - trial sequencer: random delay, stimulus LED, reaction time in ms
module reaction_timer_ctrl #(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 12,
    parameter int MAX_RT_MS    = 9999
) (
    input  logic                  clk,
    input  logic                  reset,
    reaction_timer_ctrl_if.slave  bus
);
    localparam int          TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [13:0] MIN_DELAY = 14'(MIN_DELAY_MS);
    localparam logic [13:0] RAND_MASK = 14'((1 << RAND_BITS) - 1);
    localparam logic [13:0] MAX_RT    = 14'(MAX_RT_MS);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_TIMING, S_DONE, S_EARLY, S_TIMEOUT
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] tick_cnt, tick_cnt_n;
    logic [13:0]   delay_cnt, delay_cnt_n;
    logic [13:0]   rt_ms_r, rt_ms_n, rt_inc;
    logic          rand_start_r, rand_start_n;
    logic          led_r, led_n;
    logic          valid_r, valid_n;
    logic          early_r, early_n;
    logic          tmo_r, tmo_n;
    logic          counting, tick;

    assign counting = (state == S_WAIT) || (state == S_TIMING);
    assign tick     = counting && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            tick_cnt     <= '0;
            delay_cnt    <= '0;
            rt_ms_r      <= '0;
            rand_start_r <= 1'b0;
            led_r        <= 1'b0;
            valid_r      <= 1'b0;
            early_r      <= 1'b0;
            tmo_r        <= 1'b0;
        end else begin
            state        <= state_n;
            tick_cnt     <= tick_cnt_n;
            delay_cnt    <= delay_cnt_n;
            rt_ms_r      <= rt_ms_n;
            rand_start_r <= rand_start_n;
            led_r        <= led_n;
            valid_r      <= valid_n;
            early_r      <= early_n;
            tmo_r        <= tmo_n;
        end
    end

    always_comb begin
        state_n      = state;
        delay_cnt_n  = delay_cnt;
        rt_ms_n      = rt_ms_r;
        rand_start_n = 1'b0;
        led_n        = led_r;
        valid_n      = valid_r;
        early_n      = early_r;
        tmo_n        = tmo_r;
        tick_cnt_n   = '0;
        rt_inc       = rt_ms_r + 14'(tick);

        if (bus.clear) begin
            state_n     = S_IDLE;
            delay_cnt_n = '0;
            rt_ms_n     = '0;
            led_n       = 1'b0;
            valid_n     = 1'b0;
            early_n     = 1'b0;
            tmo_n       = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state_n      = S_REQ;
                        rand_start_n = 1'b1;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (bus.stop) begin
                        state_n = S_EARLY;
                        early_n = 1'b1;
                        led_n   = 1'b0;
                        rt_ms_n = '0;
                    end else if (state == S_REQ) begin
                        if (bus.rand_done) begin
                            state_n     = S_WAIT;
                            delay_cnt_n = MIN_DELAY + (bus.rand_num & RAND_MASK);
                        end
                    end else if (tick) begin
                        // <=1 also guards a zero delay when MIN_DELAY_MS is 0
                        if (delay_cnt <= 14'd1) begin
                            state_n     = S_TIMING;
                            delay_cnt_n = '0;
                            led_n       = 1'b1;
                            rt_ms_n     = '0;
                        end else begin
                            delay_cnt_n = delay_cnt - 14'd1;
                        end
                    end
                end
                S_TIMING: begin
                    // a coincident tick is counted before the stop latches the result
                    if (bus.stop) begin
                        state_n = S_DONE;
                        rt_ms_n = rt_inc;
                        led_n   = 1'b0;
                        valid_n = 1'b1;
                    end else if (tick && (rt_inc >= MAX_RT)) begin
                        state_n = S_TIMEOUT;
                        rt_ms_n = MAX_RT;
                        led_n   = 1'b0;
                        tmo_n   = 1'b1;
                    end else begin
                        rt_ms_n = rt_inc;
                    end
                end
                S_DONE, S_EARLY, S_TIMEOUT: begin
                    if (bus.start) begin
                        state_n      = S_REQ;
                        rand_start_n = 1'b1;
                        rt_ms_n      = '0;
                        led_n        = 1'b0;
                        valid_n      = 1'b0;
                        early_n      = 1'b0;
                        tmo_n        = 1'b0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        // the ms prescaler restarts from 0 whenever WAIT or TIMING is (re)entered
        if (counting && (state_n == state))
            tick_cnt_n = tick ? '0 : tick_cnt + TW'(1);
    end

    assign bus.rand_start   = rand_start_r;
    assign bus.led          = led_r;
    assign bus.rt_ms        = rt_ms_r;
    assign bus.result_valid = valid_r;
    assign bus.too_early    = early_r;
    assign bus.timeout      = tmo_r;
endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// tb/tb_reaction_timer_ctrl.sv - scoreboard bench for reaction_timer_ctrl
module tb_reaction_timer_ctrl;
    logic clk;
    logic reset;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        int          c;
        logic [18:0] v;
        string       nm;
    } exp_t;
    exp_t exp_q[$];

    reaction_timer_ctrl_if bus();

    reaction_timer_ctrl #(
        .TICK_DIV(4), .MIN_DELAY_MS(2), .RAND_BITS(2), .MAX_RT_MS(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // output vector: {rand_start, led, rt_ms, result_valid, too_early, timeout}
    task automatic expect_at(input string nm, input int c, input logic rs, input logic ld,
                             input int rt, input logic rv, input logic te, input logic to);
        exp_t e;
        e.c  = c;
        e.v  = {rs, ld, rt[13:0], rv, te, to};
        e.nm = nm;
        exp_q.push_back(e);
    endtask

    // inputs are held for exactly one cycle and sampled at edge number target
    task automatic drive_at(input int target, input logic rst, input logic clr, input logic st,
                            input logic sp, input logic rd, input logic [13:0] rn, output int e);
        while (cyc < target - 1) begin
            @(posedge clk);
            #1;
        end
        reset         = rst;
        bus.clear     = clr;
        bus.start     = st;
        bus.stop      = sp;
        bus.rand_done = rd;
        bus.rand_num  = rn;
        @(posedge clk);
        #1;
        e             = cyc;
        reset         = 1'b0;
        bus.clear     = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.rand_done = 1'b0;
        bus.rand_num  = '0;
    endtask

    task automatic do_start(input int target, output int e);
        drive_at(target, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0, e);
    endtask
    task automatic do_stop(input int target, output int e);
        drive_at(target, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0, e);
    endtask
    task automatic do_rand(input int target, input logic [13:0] rn, output int e);
        drive_at(target, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rn, e);
    endtask
    task automatic do_clear(input int target, output int e);
        drive_at(target, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0, e);
    endtask
    task automatic do_reset(input int target, output int e);
        drive_at(target, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0, e);
    endtask

    // monitor: every change of the output vector must match the next scoreboard entry
    initial begin
        logic [18:0] prev;
        logic [18:0] cur;
        exp_t        e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = {bus.rand_start, bus.led, bus.rt_ms, bus.result_valid, bus.too_early, bus.timeout};
                checks++;
                if ($countones(cur[2:0]) > 1) begin
                    errors++;
                    $display("FAIL flags_exclusive cyc=%0d got=%b required at most one set", cyc, cur[2:0]);
                end
                if (cur !== prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change cyc=%0d got=%h required no change (prev=%h)", cyc, cur, prev);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e.v || cyc != e.c) begin
                            errors++;
                            $display("FAIL %s cyc=%0d got=%h required=%h at cyc=%0d", e.nm, cyc, cur, e.v, e.c);
                        end
                    end
                    prev = cur;
                end
            end
        end
    end

    initial begin
        int s, w, t, e;
        logic [18:0] outs;
        reset         = 1'b1;
        bus.clear     = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.rand_done = 1'b0;
        bus.rand_num  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        outs  = {bus.rand_start, bus.led, bus.rt_ms, bus.result_valid, bus.too_early, bus.timeout};
        checks++;
        if (outs !== 19'h0) begin
            errors++;
            $display("FAIL reset_state got=%h required=%h", outs, 19'h0);
        end
        mon_en = 1'b1;

        // normal trial: delay 2+3=5 ms, stop on the 7th TIMING tick -> 7 ms
        do_start(0, s);
        expect_at("t1_rand_start", s, 1, 0, 0, 0, 0, 0);
        expect_at("t1_rand_start_drop", s + 1, 0, 0, 0, 0, 0, 0);
        do_rand(s + 3, 14'h3FF7, e);
        t = e + 20;
        expect_at("t1_led_on", t, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 6; k++) expect_at("t1_rt_inc", t + 4 * k, 0, 1, k, 0, 0, 0);
        do_stop(t + 28, e);
        expect_at("t1_done", t + 28, 0, 0, 7, 1, 0, 0);

        // restart from DONE; stop on the first WAIT tick is early
        do_start(0, s);
        expect_at("t2_restart", s, 1, 0, 0, 0, 0, 0);
        expect_at("t2_rand_start_drop", s + 1, 0, 0, 0, 0, 0, 0);
        do_rand(s + 1, 14'h0000, e);
        w = e;
        do_stop(w + 4, e);
        expect_at("t2_early", w + 4, 0, 0, 0, 0, 1, 0);

        // stop coincident with the final WAIT tick
        do_start(0, s);
        expect_at("t3_restart", s, 1, 0, 0, 0, 0, 0);
        expect_at("t3_rand_start_drop", s + 1, 0, 0, 0, 0, 0, 0);
        do_rand(s + 2, 14'h0000, e);
        w = e;
        do_stop(w + 8, e);
        expect_at("t3_early_final_tick", w + 8, 0, 0, 0, 0, 1, 0);

        // timeout: delay 3 ms, no stop; stray rand_done/start/stop are ignored
        do_start(w + 16, s);
        expect_at("t4_restart", s, 1, 0, 0, 0, 0, 0);
        expect_at("t4_rand_start_drop", s + 1, 0, 0, 0, 0, 0, 0);
        do_rand(s + 1, 14'h0001, e);
        w = e;
        t = w + 12;
        do_rand(w + 5, 14'h3FFF, e);
        expect_at("t4_led_on", t, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 19; k++) expect_at("t4_rt_inc", t + 4 * k, 0, 1, k, 0, 0, 0);
        expect_at("t4_timeout", t + 80, 0, 0, 20, 0, 0, 1);
        do_start(t + 6, e);
        do_stop(t + 82, e);

        // stop coincident with a TIMING tick at rt_ms=4 -> 5
        do_start(t + 86, s);
        expect_at("t5_restart", s, 1, 0, 0, 0, 0, 0);
        expect_at("t5_rand_start_drop", s + 1, 0, 0, 0, 0, 0, 0);
        do_rand(s + 2, 14'h0002, e);
        w = e;
        t = w + 16;
        do_start(w + 3, e);
        expect_at("t5_led_on", t, 0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) expect_at("t5_rt_inc", t + 4 * k, 0, 1, k, 0, 0, 0);
        do_stop(t + 20, e);
        expect_at("t5_done_tick_stop", t + 20, 0, 0, 5, 1, 0, 0);

        // clear mid-TIMING, fresh start, then reset mid-TIMING
        do_start(0, s);
        expect_at("t6_restart", s, 1, 0, 0, 0, 0, 0);
        expect_at("t6_rand_start_drop", s + 1, 0, 0, 0, 0, 0, 0);
        do_rand(s + 1, 14'h0000, e);
        t = e + 8;
        expect_at("t6_led_on", t, 0, 1, 0, 0, 0, 0);
        expect_at("t6_rt_inc", t + 4, 0, 1, 1, 0, 0, 0);
        do_clear(t + 6, e);
        expect_at("t6_clear", t + 6, 0, 0, 0, 0, 0, 0);
        do_start(t + 8, s);
        expect_at("t6_start_after_clear", s, 1, 0, 0, 0, 0, 0);
        expect_at("t6_rand_start_drop2", s + 1, 0, 0, 0, 0, 0, 0);
        do_rand(s + 1, 14'h0000, e);
        t = e + 8;
        expect_at("t6_led_on2", t, 0, 1, 0, 0, 0, 0);
        do_reset(t + 2, e);
        expect_at("t6_reset_mid_trial", t + 2, 0, 0, 0, 0, 0, 0);
        do_stop(t + 4, e);

        // stop in REQ is early; the later rand_done is ignored
        do_start(t + 6, s);
        expect_at("t7_start", s, 1, 0, 0, 0, 0, 0);
        expect_at("t7_rand_start_drop", s + 1, 0, 0, 0, 0, 0, 0);
        do_stop(s + 2, e);
        expect_at("t7_early_in_req", s + 2, 0, 0, 0, 0, 1, 0);
        do_rand(s + 3, 14'h0003, e);

        repeat (40) @(posedge clk);
        #1;
        mon_en = 1'b0;
        while (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s never seen, required=%h at cyc=%0d", x.nm, x.v, x.c);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
